truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Exhaustively drives all 2^N_IN input combinations onto a combinational DUT and holds each one for a programmable dwell time.
- Samples the DUT outputs into an internal truth-table memory and counts output-0 minterms.
- Gives lab DUTs a synthesizable, reusable stimulus/capture engine in place of hand-written per-vector delays.
- Sits beside the DUT: vec_out feeds the DUT inputs, and the DUT outputs return on dut_out.

Parameters:
- N_IN, 4, number of DUT inputs; vector width; 2^N_IN vectors per sweep (range 1..8).
- N_OUT, 1, number of DUT outputs captured per vector.
- DWELL, 1, clock cycles each vector is held (>=1); the sample is taken in the last dwell cycle.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin sweep; honoured only in IDLE.
- mode  in  1  0 = binary count order, 1 = Gray-code order; latched on accepted start.
- dut_out  in  N_OUT  DUT outputs; combinational response to vec_out.
- vec_out  out  N_IN  current stimulus vector; bit N_IN-1 is the MSB ("a").
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when the sweep completes.
- tt_valid  out  1  captured table complete; cleared by start or reset.
- ones_count  out  N_IN+1  number of vectors with dut_out[0]=1.
- rd_addr  in  N_IN  truth-table read address, equal to the vector value.
- rd_data  out  N_OUT  combinational read of the captured entry at rd_addr.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; vec_out=0, busy=0, done=0, tt_valid=0, ones_count=0; index and dwell counters 0.
  - Memory is not cleared, but is invalid until tt_valid=1.
  - Reset mid-sweep aborts the sweep immediately, with the same values.
- States: IDLE, SWEEP, DONE.
- IDLE + start=1:
  - Next cycle: SWEEP, idx=0, dwell=0, busy=1, tt_valid=0, ones_count=0.
  - mode is latched.
- SWEEP:
  - vec_out = idx in binary mode, or idx ^ (idx>>1) in Gray mode.
  - dwell increments each cycle.
  - When dwell==DWELL-1: write dut_out to mem[vec_out] (addressed by vector value, not sequence index), add dut_out[0] to ones_count, then idx++ and dwell=0.
  - After the entry for idx=2^N_IN-1 is written: next state DONE.
- DONE (one cycle): done=1, busy=0, tt_valid=1, vec_out holds the last vector; next state IDLE.
- Latency: with start sampled at edge 0, done is high in cycle 1 + 2^N_IN*DWELL.
- Ignored inputs:
  - start in SWEEP or DONE has no effect.
  - start in the DONE cycle is not queued.
- Readback:
  - rd_data is valid for any rd_addr at any time.
  - During a sweep, entries not yet written hold stale data.
- Arithmetic:
  - idx is N_IN+1 bits wide to detect the terminal count without wrap.
  - ones_count cannot overflow (maximum 2^N_IN).

Optional Feature:
- Macro TT_CHECK_EN.
- When defined, these are added:
  - Input exp_tt [2^N_IN-1:0], the golden truth table for dut_out[0], indexed by vector value and sampled on the same cycle as each write.
  - Output mismatch (1): sticky; set on the first sample where dut_out[0] != exp_tt[vec_out]; cleared by start or reset.
  - Output first_fail_idx (N_IN): the vector value of the first mismatch; reset value 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package tt_sweep_pkg holds:
  - The state enum (IDLE/SWEEP/DONE).
  - Mode constants MODE_BIN=0 and MODE_GRAY=1.
  - A function for the Gray encode.
- One sub-module, tt_seq_gen: a combinational idx+mode to vec_out encoder, reused by later pattern generators.

Test Plan:
- N_IN=4, DWELL=1, binary mode, dut_out=(a&b)|(c&d), start pulse at cycle 0:
  - vec_out steps 0..15 in cycles 1..16.
  - done=1 in cycle 17; ones_count=7; tt_valid=1.
  - rd_addr=15 gives 1; rd_addr=5 gives 0.
- Same DUT in Gray mode:
  - vec_out in cycles 1..4 = 0,1,3,2.
  - ones_count=7; captured table identical to binary mode (same values at every rd_addr).
- DWELL=3:
  - Each vector held 3 cycles; done in cycle 49.
  - A glitch on dut_out in the first two dwell cycles of a vector does not affect capture.
- Reset mid-sweep (rst_n=0 sampled at cycle 8):
  - Next cycle: busy=0, vec_out=0, ones_count=0, tt_valid=0, no done.
  - A new start then completes normally.
- start pulsed at cycle 5 during a sweep:
  - No effect; done still in cycle 17.
- TT_CHECK_EN, exp_tt=16'hF888:
  - mismatch=0 after the sweep.
- TT_CHECK_EN, exp_tt=16'hF808:
  - mismatch=1 and first_fail_idx=7.
  - Both are cleared by the next start.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper and related pattern
// generators: FSM state encoding, sweep-order constants, Gray encoder.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // Widest vector any sweeper in this family supports.
  localparam int MAX_N_IN = 8;

  // Binary to reflected Gray code; callers zero-extend narrower vectors.
  function automatic logic [MAX_N_IN-1:0] gray_encode(input logic [MAX_N_IN-1:0] bin);
    return bin ^ (bin >> 3'd1);
  endfunction

endpackage

// File: rtl/tt_seq_gen.sv
// Combinational sweep-order encoder: maps a sequence index to the stimulus
// vector, either straight binary or Gray-code order.
module tt_seq_gen
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] idx,
  input  logic            mode,
  output logic [N_IN-1:0] vec
);

  // Select binary or Gray ordering for the given index.
  always_comb begin
    vec = idx;
    if (mode == MODE_GRAY) begin
      vec = N_IN'(gray_encode(MAX_N_IN'(idx)));
    end else begin
      vec = idx;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input combination onto a combinational
// DUT, holds each for DWELL cycles, captures the DUT response into a table
// addressed by vector value and counts vectors with dut_out[0]=1.
// Optional golden-table comparison is enabled by defining TT_CHECK_EN.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int DWELL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [N_OUT-1:0]   dut_out,
  output logic [N_IN-1:0]    vec_out,
  output logic               busy,
  output logic               done,
  output logic               tt_valid,
  output logic [N_IN:0]      ones_count,
  input  logic [N_IN-1:0]    rd_addr,
  output logic [N_OUT-1:0]   rd_data
`ifdef TT_CHECK_EN
  ,
  input  logic [2**N_IN-1:0] exp_tt,
  output logic               mismatch,
  output logic [N_IN-1:0]    first_fail_idx
`endif
);

  localparam int IDX_W = N_IN + 1;
  localparam int NVEC  = 2 ** N_IN;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  // Index of the final vector; idx has one spare bit so it never wraps.
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NVEC - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DW_W-1:0]    dwell_r;
  logic               mode_r;
  logic [N_IN-1:0]    vec_out_r;
  logic               busy_r;
  logic               done_r;
  logic               tt_valid_r;
  logic [N_IN:0]      ones_count_r;
  logic [N_OUT-1:0]   mem_r [NVEC];

  logic               sample_s;
  logic               last_s;
  logic [IDX_W-1:0]   next_idx_s;
  logic [N_IN-1:0]    next_vec_s;

  // Sample strobe in the final dwell cycle of each vector, and next index.
  always_comb begin
    sample_s   = 1'b0;
    last_s     = 1'b0;
    next_idx_s = idx_r + IDX_W'(1);
    if (state_r == SWEEP) begin
      sample_s = (dwell_r == DWELL_LAST);
      last_s   = (idx_r == LAST_IDX);
    end else begin
      sample_s = 1'b0;
      last_s   = 1'b0;
    end
  end

  // Vector the sweep moves to once the current one has been captured.
  tt_seq_gen #(
    .N_IN (N_IN)
  ) u_seq_gen (
    .idx  (next_idx_s[N_IN-1:0]),
    .mode (mode_r),
    .vec  (next_vec_s)
  );

  // Sweep control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      dwell_r      <= '0;
      mode_r       <= MODE_BIN;
      vec_out_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      tt_valid_r   <= 1'b0;
      ones_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r      <= SWEEP;
            idx_r        <= '0;
            dwell_r      <= '0;
            mode_r       <= mode;
            vec_out_r    <= '0;
            busy_r       <= 1'b1;
            tt_valid_r   <= 1'b0;
            ones_count_r <= '0;
          end
        end
        SWEEP: begin
          if (sample_s) begin
            ones_count_r <= ones_count_r + (N_IN+1)'(dut_out[0]);
            dwell_r      <= '0;
            idx_r        <= next_idx_s;
            if (last_s) begin
              // vec_out keeps the last vector through the DONE cycle.
              state_r    <= DONE;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              tt_valid_r <= 1'b1;
            end else begin
              vec_out_r  <= next_vec_s;
            end
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Capture table, addressed by vector value; not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && sample_s) begin
      mem_r[vec_out_r] <= dut_out;
    end
  end

`ifdef TT_CHECK_EN
  logic            mismatch_r;
  logic [N_IN-1:0] first_fail_idx_r;

  // Sticky golden-table comparison; remembers the first failing vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_r       <= 1'b0;
      first_fail_idx_r <= '0;
    end else if ((state_r == IDLE) && start) begin
      mismatch_r       <= 1'b0;
      first_fail_idx_r <= '0;
    end else if (sample_s && !mismatch_r && (dut_out[0] != exp_tt[vec_out_r])) begin
      mismatch_r       <= 1'b1;
      first_fail_idx_r <= vec_out_r;
    end
  end

  assign mismatch       = mismatch_r;
  assign first_fail_idx = first_fail_idx_r;
`endif

  assign vec_out    = vec_out_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign tt_valid   = tt_valid_r;
  assign ones_count = ones_count_r;
  assign rd_data    = mem_r[rd_addr];

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (DWELL=1 and
// DWELL=3) sweep random and fixed truth tables in both orders; expected
// sequences, counts and captured tables come from a simple table model.
module tb_truth_table_sweeper;

  localparam int N_IN = 4;
  localparam int NVEC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start    [2];
  logic        mode     [2];
  logic [0:0]  dut_out  [2];
  logic [3:0]  vec      [2];
  logic        busy     [2];
  logic        done     [2];
  logic        tt_valid [2];
  logic [4:0]  ones     [2];
  logic [3:0]  rd_addr  [2];
  logic [0:0]  rd_data  [2];
  logic [15:0] tt_cur   [2];
  logic        glitch   [2];
`ifdef TT_CHECK_EN
  logic [15:0] exp_tt   [2];
  logic        mism     [2];
  logic [3:0]  ffi      [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Modelled combinational DUT: table lookup, optionally inverted (glitch).
  assign dut_out[0] = tt_cur[0][vec[0]] ^ glitch[0];
  assign dut_out[1] = tt_cur[1][vec[1]] ^ glitch[1];

  truth_table_sweeper #(.N_IN(4), .N_OUT(1), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
    .dut_out(dut_out[0]), .vec_out(vec[0]), .busy(busy[0]), .done(done[0]),
    .tt_valid(tt_valid[0]), .ones_count(ones[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0])
`ifdef TT_CHECK_EN
    , .exp_tt(exp_tt[0]), .mismatch(mism[0]), .first_fail_idx(ffi[0])
`endif
  );

  truth_table_sweeper #(.N_IN(4), .N_OUT(1), .DWELL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
    .dut_out(dut_out[1]), .vec_out(vec[1]), .busy(busy[1]), .done(done[1]),
    .tt_valid(tt_valid[1]), .ones_count(ones[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1])
`ifdef TT_CHECK_EN
    , .exp_tt(exp_tt[1]), .mismatch(mism[1]), .first_fail_idx(ffi[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector visited at step i of a sweep.
  function automatic int order_vec(input bit md, input int i);
    return md ? (i ^ (i >> 1)) : i;
  endfunction

  // Full sweep on instance u; caller is positioned at a negedge.
  task automatic run_sweep(input int u, input bit md, input logic [15:0] tbl,
                           input logic [15:0] gold, input int poke_cycle,
                           input bit start_in_done, input bit do_glitch);
    int d;
    int total;
    int exp_ones;
    int first_fail;
    int v;
    d = (u == 0) ? 1 : 3;
    total = NVEC * d;
    exp_ones = $countones(tbl);
    first_fail = -1;
    for (int i = 0; i < NVEC; i++) begin
      v = order_vec(md, i);
      if (first_fail < 0 && tbl[v] != gold[v]) first_fail = v;
    end
    tt_cur[u] = tbl;
`ifdef TT_CHECK_EN
    exp_tt[u] = gold;
`endif
    mode[u]  = md;
    start[u] = 1'b1;
    @(posedge clk);
    #1 start[u] = 1'b0;
    mode[u] = ~md;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      check($sformatf("vec u%0d k%0d", u, k), vec[u], order_vec(md, (k - 1) / d));
      check($sformatf("busy u%0d k%0d", u, k), busy[u], 1'b1);
      check($sformatf("done_early u%0d k%0d", u, k), done[u], 1'b0);
      if (k == 1) begin
        check("tt_valid_cleared", tt_valid[u], 1'b0);
`ifdef TT_CHECK_EN
        check("mismatch_cleared", mism[u], 1'b0);
`endif
      end
      glitch[u] = do_glitch && (((k - 1) % d) != d - 1);
      start[u]  = (k == poke_cycle);
    end
    @(negedge clk);
    glitch[u] = 1'b0;
    start[u]  = start_in_done;
    check("done_pulse", done[u], 1'b1);
    check("busy_done", busy[u], 1'b0);
    check("tt_valid_set", tt_valid[u], 1'b1);
    check("vec_hold_last", vec[u], order_vec(md, NVEC - 1));
    check("ones_count", ones[u], exp_ones);
`ifdef TT_CHECK_EN
    check("mismatch", mism[u], first_fail >= 0);
    if (first_fail >= 0) check("first_fail_idx", ffi[u], first_fail);
`endif
    @(negedge clk);
    start[u] = 1'b0;
    check("done_one_cycle", done[u], 1'b0);
    check("idle_no_queue", busy[u], 1'b0);
    check("tt_valid_hold", tt_valid[u], 1'b1);
    for (int a = 0; a < NVEC; a++) begin
      rd_addr[u] = a[3:0];
      #1;
      check($sformatf("rd u%0d a%0d", u, a), rd_data[u], tbl[a]);
    end
    @(negedge clk);
  endtask

  logic [15:0] rtbl;
  logic [15:0] rgold;

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; mode[u] = 1'b0; rd_addr[u] = 4'd0;
      tt_cur[u] = 16'h0000; glitch[u] = 1'b0;
`ifdef TT_CHECK_EN
      exp_tt[u] = 16'h0000;
`endif
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_vec", vec[u], 4'd0);
      check("rst_busy", busy[u], 1'b0);
      check("rst_done", done[u], 1'b0);
      check("rst_tt_valid", tt_valid[u], 1'b0);
      check("rst_ones", ones[u], 5'd0);
`ifdef TT_CHECK_EN
      check("rst_mismatch", mism[u], 1'b0);
      check("rst_ffi", ffi[u], 4'd0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    // (a&b)|(c&d) in binary order, then explicit spot reads.
    run_sweep(0, 1'b0, 16'hF888, 16'hF888, -1, 1'b0, 1'b0);
    rd_addr[0] = 4'd15; #1 check("rd15", rd_data[0], 1'b1);
    rd_addr[0] = 4'd5;  #1 check("rd5", rd_data[0], 1'b0);
    @(negedge clk);
    // Gray order with a golden table that differs at vector 7.
    run_sweep(0, 1'b1, 16'hF888, 16'hF808, -1, 1'b0, 1'b0);
    // Stray start mid-sweep.
    run_sweep(0, 1'b0, 16'hF888, 16'hF888, 5, 1'b0, 1'b0);
    // DWELL=3 with glitches and a start during DONE.
    run_sweep(1, 1'b0, 16'hF888, 16'hF888, -1, 1'b1, 1'b1);
    run_sweep(1, 1'b1, 16'h3C5A, 16'h3C5B, 7, 1'b0, 1'b1);

    // Reset sampled at the end of cycle 8 of a sweep.
    tt_cur[0] = 16'hFFFF;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_vec", vec[0], 4'd0);
    check("midrst_ones", ones[0], 5'd0);
    check("midrst_tt_valid", tt_valid[0], 1'b0);
    check("midrst_done", done[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 1'b0, 16'hF888, 16'hF888, -1, 1'b0, 1'b0);

    // Randomised sweeps.
    for (int r = 0; r < 8; r++) begin
      rtbl  = 16'($urandom_range(0, 65535));
      rgold = ($urandom_range(0, 1) == 0) ? rtbl : (rtbl ^ 16'($urandom_range(1, 65535)));
      run_sweep($urandom_range(0, 1), 1'($urandom_range(0, 1)), rtbl, rgold,
                $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
